uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DEPTH, default 16: number of byte entries; power of two, minimum 2.
REQ-002 Parameter DATA_W, default 8: byte width, equal to the uart data width.
REQ-003 clk  input  1: single clock; all logic SHALL be rising-edge clocked on clk.
REQ-004 rst  input  1: synchronous, active-high reset.
REQ-005 uart_dout  input  DATA_W: received byte from uart dout; valid while uart_rd_rdy=1.
REQ-006 uart_rd_rdy  input  1: uart holds an unread byte.
REQ-007 uart_rd_en  output  1: one-cycle pop strobe to uart rd_en.
REQ-008 rd_en  input  1: host pop request.
REQ-009 dout  output  DATA_W: head-of-FIFO byte (first-word-fall-through).
REQ-010 empty  output  1: FIFO holds 0 entries.
REQ-011 full  output  1: FIFO holds DEPTH entries.
REQ-012 count  output  log2(DEPTH)+1: current occupancy, 0..DEPTH.
REQ-013 overflow  output  1: sticky flag, a received byte was dropped.
REQ-014 clr_ovf  input  1: clears overflow.

Function
REQ-015 The capture FSM SHALL have states IDLE, ACK and WAIT.
REQ-016 In IDLE with uart_rd_rdy=1 and count<DEPTH at cycle start, uart_dout SHALL be written at wr_ptr, wr_ptr SHALL increment modulo DEPTH, and the next state SHALL be ACK.
REQ-017 In IDLE with uart_rd_rdy=1 and count=DEPTH, the byte SHALL be discarded, overflow SHALL be set, and the next state SHALL be ACK; the uart is still popped.
REQ-018 In ACK, uart_rd_en SHALL be 1 for exactly that one cycle, and the next state SHALL be WAIT.
REQ-019 In WAIT, the FSM SHALL return to IDLE on the first cycle uart_rd_rdy=0; uart_dout SHALL be ignored while in WAIT.
REQ-020 uart_rd_en SHALL be 0 in every state other than ACK.
REQ-021 Host pop: rd_en=1 with count>0 at cycle start SHALL advance rd_ptr modulo DEPTH; rd_en while empty SHALL be ignored with no state change.
REQ-022 dout SHALL equal mem[rd_ptr] combinationally when empty=0, and SHALL be 0 when empty=1.
REQ-023 Write-to-visible latency: a byte captured on edge N SHALL appear on dout, with empty=0, after edge N.
REQ-024 On a simultaneous write and pop, count SHALL be unchanged and both pointers SHALL advance.
REQ-025 Full plus pop in the same cycle: fullness SHALL be judged at cycle start, so the incoming byte is dropped and overflow is set.
REQ-026 Empty plus write plus rd_en in the same cycle: the pop SHALL be ignored and count SHALL become 1.
REQ-027 empty, full and count SHALL be derived from registered state only, with no combinational path from any input.
REQ-028 overflow SHALL stay set until clr_ovf=1; when set and clear coincide, set SHALL win.
REQ-029 Pointers SHALL be log2(DEPTH) bits and wrap naturally; count SHALL saturate neither below 0 nor above DEPTH, both enforced by REQ-016/021.

Reset
REQ-030 rst=1 at a clk edge SHALL force state=IDLE, wr_ptr=0, rd_ptr=0, count=0, overflow=0 and uart_rd_en=0, giving empty=1, full=0 and dout=0.
REQ-031 Storage contents SHALL NOT be reset.
REQ-032 rst SHALL override all other inputs in the same cycle.
REQ-033 Reset asserted in ACK SHALL suppress that cycle's uart_rd_en.
REQ-034 After reset deasserts, a byte still pending at the uart SHALL be captured normally from IDLE.

Structure
REQ-035 DATA_W, the default DEPTH and the FSM state encodings (IDLE=0, ACK=1, WAIT=2) SHALL live in shared package uart_pkg, also used by uart.
REQ-036 Storage SHALL be a sub-module fifo_ram: DEPTH x DATA_W, synchronous write, asynchronous read, no reset.

Verification
REQ-037 Reset then idle: rst high for 2 cycles, uart_rd_rdy=0 -> empty=1, count=0, dout=0, uart_rd_en=0, overflow=0.
REQ-038 Single byte: uart_dout=125, uart_rd_rdy=1 until uart_rd_en seen -> exactly one uart_rd_en pulse 1 cycle after capture, dout=125, count=1; rd_en pulse -> empty=1.
REQ-039 Fill and overflow: 17 bytes 0..16, no host pops -> full=1, count=16, 17 uart_rd_en pulses, overflow=1; then 16 pops return 0..15 in order.
REQ-040 Wrap-around: interleave 40 writes (values 47+i) with pops keeping count between 1 and 3 -> output sequence 47..86 with no loss.
REQ-041 Simultaneous: count=5 with capture and rd_en in the same cycle -> count stays 5; at count=0 with write and rd_en together -> count=1 and dout equals the new byte.
REQ-042 Mid-operation reset and sticky clear: rst asserted in ACK -> no uart_rd_en that cycle and empty=1; overflow set, then clr_ovf coinciding with a new drop -> overflow stays 1; then clr_ovf alone -> overflow=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, default receive FIFO depth and capture FSM encoding.
package uart_pkg;

   localparam int unsigned DATA_W        = 8;
   localparam int unsigned DEFAULT_DEPTH = 16;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StAck  = 2'd1,
      StWait = 2'd2
   } cap_state_e;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Signal bundle between the uart receiver, the rx FIFO and its host.
interface uart_rx_fifo_if #(
   parameter int unsigned DEPTH  = uart_pkg::DEFAULT_DEPTH,
   parameter int unsigned DATA_W = uart_pkg::DATA_W
);

   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic [DATA_W-1:0] uart_dout;
   logic              uart_rd_rdy;
   logic              uart_rd_en;
   logic              rd_en;
   logic [DATA_W-1:0] dout;
   logic              empty;
   logic              full;
   logic [CNT_W-1:0]  count;
   logic              overflow;
   logic              clr_ovf;

   // Driven by the uart model / host side.
   modport master (
      output uart_dout, uart_rd_rdy, rd_en, clr_ovf,
      input  uart_rd_en, dout, empty, full, count, overflow
   );

   // The FIFO itself.
   modport slave (
      input  uart_dout, uart_rd_rdy, rd_en, clr_ovf,
      output uart_rd_en, dout, empty, full, count, overflow
   );

endinterface

// File: rtl/fifo_ram.sv
// DEPTH x DATA_W storage: synchronous write, asynchronous read, contents never reset.
module fifo_ram #(
   parameter int unsigned DEPTH  = uart_pkg::DEFAULT_DEPTH,
   parameter int unsigned DATA_W = uart_pkg::DATA_W
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [DATA_W-1:0]        wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [DATA_W-1:0]        rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind a uart: captures each pending byte, pops the uart once, buffers for the host.
module uart_rx_fifo #(
   parameter int unsigned DEPTH  = uart_pkg::DEFAULT_DEPTH,
   parameter int unsigned DATA_W = uart_pkg::DATA_W
) (
   input logic           clk,
   input logic           rst,
   uart_rx_fifo_if.slave bus
);

   localparam int unsigned AW    = $clog2(DEPTH);
   localparam int unsigned CNT_W = AW + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   uart_pkg::cap_state_e state_q, state_d;

   logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              ovf_q, ovf_d;
   logic              is_empty, is_full;
   logic              wr, drop, pop;
   logic [DATA_W-1:0] ram_rdata;

   // Flags come from registered occupancy only.
   assign is_empty = (count_q == '0);
   assign is_full  = (count_q == FULL_CNT);

   always_comb begin
      state_d = state_q;
      wr      = 1'b0;
      drop    = 1'b0;
      unique case (state_q)
         uart_pkg::StIdle: begin
            if (bus.uart_rd_rdy) begin
               wr      = ~is_full;
               drop    = is_full;
               state_d = uart_pkg::StAck;
            end
         end
         uart_pkg::StAck: begin
            state_d = uart_pkg::StWait;
         end
         uart_pkg::StWait: begin
            // The uart keeps rd_rdy high until it has retired the popped byte.
            if (!bus.uart_rd_rdy) begin
               state_d = uart_pkg::StIdle;
            end
         end
         default: begin
            state_d = uart_pkg::StIdle;
         end
      endcase
   end

   // Pop is judged on start-of-cycle occupancy, so a write into an empty FIFO cannot be popped.
   assign pop     = bus.rd_en & ~is_empty;
   assign count_d = count_q + CNT_W'(wr) - CNT_W'(pop);
   assign ovf_d   = drop | (ovf_q & ~bus.clr_ovf);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= uart_pkg::StIdle;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         if (wr) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
      end
   end

   fifo_ram #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
   ) u_ram (
      .clk   (clk),
      .we    (wr & ~rst),
      .waddr (wr_ptr_q),
      .wdata (bus.uart_dout),
      .raddr (rd_ptr_q),
      .rdata (ram_rdata)
   );

   // Gated by rst so a reset landing in ACK never pops the uart.
   assign bus.uart_rd_en = (state_q == uart_pkg::StAck) & ~rst;
   assign bus.dout       = is_empty ? '0 : ram_rdata;
   assign bus.empty      = is_empty;
   assign bus.full       = is_full;
   assign bus.count      = count_q;
   assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: uart model feeds bytes, monitor checks every host pop.
module tb_uart_rx_fifo;

   localparam int unsigned DEPTH  = 16;
   localparam int unsigned DATA_W = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   uart_rx_fifo_if #(.DEPTH(DEPTH), .DATA_W(DATA_W)) bus ();

   uart_rx_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_vec     = 0;
   int n_fail    = 0;
   int pulse_cnt = 0;
   logic [DATA_W-1:0] tx_q  [$];
   logic [DATA_W-1:0] exp_q [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   task automatic fail_now(input string name);
      n_vec++;
      n_fail++;
      $display("FAIL %s", name);
   endtask

   // Uart model: presents the next byte, retires it after seeing the rd_en pulse.
   initial begin : uart_model
      logic en;
      bus.uart_rd_rdy = 1'b0;
      bus.uart_dout   = '0;
      forever begin
         @(negedge clk);
         en = bus.uart_rd_en;
         @(posedge clk);
         #1;
         if (en) begin
            pulse_cnt++;
            bus.uart_rd_rdy = 1'b0;
         end else if (!bus.uart_rd_rdy && tx_q.size() > 0) begin
            bus.uart_dout   = tx_q.pop_front();
            bus.uart_rd_rdy = 1'b1;
         end
      end
   end

   // Monitor: every accepted host pop must present the oldest expected byte.
   initial begin : monitor
      logic prev_en;
      prev_en = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.uart_rd_en) check("uart_rd_en_single_cycle", 32'(prev_en), 0);
         prev_en = bus.uart_rd_en;
         if (bus.rd_en && !bus.empty && !rst) begin
            if (exp_q.size() == 0) fail_now("sb_unexpected_byte");
            else check("sb_dout", 32'(bus.dout), 32'(exp_q.pop_front()));
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic send(input logic [DATA_W-1:0] b, input bit kept);
      tx_q.push_back(b);
      if (kept) exp_q.push_back(b);
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((tx_q.size() > 0 || bus.uart_rd_rdy) && n < 300) begin
         tick();
         n++;
      end
      if (n >= 300) fail_now("wait_idle_timeout");
      tick();
      tick();
   endtask

   task automatic wait_count(input int c);
      int n = 0;
      while (int'(bus.count) != c && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) fail_now("wait_count_timeout");
   endtask

   task automatic pop();
      bus.rd_en = 1'b1;
      tick();
      bus.rd_en = 1'b0;
   endtask

   initial begin : main
      int p0;
      bus.rd_en   = 1'b0;
      bus.clr_ovf = 1'b0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;

      // Reset state
      check("rst_empty", 32'(bus.empty), 1);
      check("rst_full", 32'(bus.full), 0);
      check("rst_count", 32'(bus.count), 0);
      check("rst_dout", 32'(bus.dout), 0);
      check("rst_uart_rd_en", 32'(bus.uart_rd_en), 0);
      check("rst_overflow", 32'(bus.overflow), 0);

      // Single byte
      p0 = pulse_cnt;
      send(8'd125, 1'b1);
      wait_count(1);
      check("single_ack_after_capture", 32'(bus.uart_rd_en), 1);
      check("single_visible_empty", 32'(bus.empty), 0);
      check("single_visible_dout", 32'(bus.dout), 125);
      wait_idle();
      check("single_pulses", 32'(pulse_cnt - p0), 1);
      check("single_count", 32'(bus.count), 1);
      pop();
      check("single_empty_after_pop", 32'(bus.empty), 1);

      // Fill and overflow
      p0 = pulse_cnt;
      for (int i = 0; i < 17; i++) send(DATA_W'(i), i < 16);
      wait_idle();
      check("fill_full", 32'(bus.full), 1);
      check("fill_count", 32'(bus.count), 16);
      check("fill_pulses", 32'(pulse_cnt - p0), 17);
      check("fill_overflow", 32'(bus.overflow), 1);
      for (int i = 0; i < 16; i++) pop();
      check("fill_drained_empty", 32'(bus.empty), 1);
      bus.clr_ovf = 1'b1;
      tick();
      bus.clr_ovf = 1'b0;
      check("fill_ovf_cleared", 32'(bus.overflow), 0);

      // Wrap-around with interleaved pops
      for (int i = 0; i < 40; i++) begin
         send(DATA_W'(47 + i), 1'b1);
         wait_idle();
         if (bus.count >= 2) pop();
      end
      check("wrap_count_in_range", 32'(bus.count >= 1 && bus.count <= 3), 1);
      for (int n = 0; n < 8 && bus.count != 0; n++) pop();
      check("wrap_no_loss", 32'(exp_q.size()), 0);
      check("wrap_empty", 32'(bus.empty), 1);

      // Simultaneous capture and pop at count 5
      for (int i = 0; i < 5; i++) send(DATA_W'(100 + i), 1'b1);
      wait_idle();
      check("simul_pre_count", 32'(bus.count), 5);
      send(8'd105, 1'b1);
      tick();
      bus.rd_en = 1'b1;
      tick();
      bus.rd_en = 1'b0;
      check("simul_count_held", 32'(bus.count), 5);
      wait_idle();
      for (int i = 0; i < 5; i++) pop();
      check("simul_drained", 32'(bus.empty), 1);

      // Write plus rd_en while empty
      send(8'd200, 1'b1);
      tick();
      bus.rd_en = 1'b1;
      tick();
      bus.rd_en = 1'b0;
      check("empty_wr_pop_count", 32'(bus.count), 1);
      check("empty_wr_pop_dout", 32'(bus.dout), 200);
      wait_idle();
      pop();

      // Reset in ACK
      p0 = pulse_cnt;
      send(8'hA5, 1'b1);
      wait_count(1);
      rst = 1'b1;
      #1;
      check("rst_in_ack_rd_en", 32'(bus.uart_rd_en), 0);
      tick();
      rst = 1'b0;
      check("rst_in_ack_empty", 32'(bus.empty), 1);
      wait_idle();
      check("rst_recapture_count", 32'(bus.count), 1);
      check("rst_recapture_pulses", 32'(pulse_cnt - p0), 1);
      pop();

      // Sticky overflow: set wins over clear, then clear alone
      for (int i = 0; i < 17; i++) send(DATA_W'(16 + i), i < 16);
      wait_idle();
      check("ovf_set", 32'(bus.overflow), 1);
      send(8'd99, 1'b0);
      tick();
      bus.clr_ovf = 1'b1;
      tick();
      bus.clr_ovf = 1'b0;
      check("ovf_set_wins", 32'(bus.overflow), 1);
      wait_idle();
      bus.clr_ovf = 1'b1;
      tick();
      bus.clr_ovf = 1'b0;
      check("ovf_clear_alone", 32'(bus.overflow), 0);
      for (int i = 0; i < 16; i++) pop();
      check("final_empty", 32'(bus.empty), 1);
      check("final_sb_drained", 32'(exp_q.size()), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
